// File: rtl/mem_access_ctrl.sv
// Load/store access controller for a 128-byte data RAM: IDLE -> ACCESS -> RESP handshake.
// Optional macro MEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into faults.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_u_b_h_w,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [2:0]  mem_u_b_h_w,
  output logic        mem_we,
  input  logic [31:0] mem_dout,
  output logic [15:0] ld_count,
  output logic [15:0] st_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q, size_d;
  logic        fault_q, fault_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_fault_q, resp_fault_d;
  logic [15:0] ld_count_q, ld_count_d;
  logic [15:0] st_count_q, st_count_d;
  logic        req_fault;

  // Fault is decided on the incoming request so ACCESS can gate the write directly.
  always_comb begin
    req_fault = (req_addr[31:7] != 25'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    if (req_u_b_h_w[1]) begin
      req_fault = req_fault | (req_addr[1:0] != 2'b00);
    end else if (req_u_b_h_w[0]) begin
      req_fault = req_fault | req_addr[0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   if (resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    fault_d      = fault_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;
    ld_count_d   = ld_count_q;
    st_count_d   = st_count_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_u_b_h_w;
          fault_d = req_fault;
        end
      end
      S_ACCESS: begin
        resp_rdata_d = (!we_q && !fault_q) ? mem_dout : 32'd0;
        resp_fault_d = fault_q;
      end
      S_RESP: begin
        // Counters advance only once the response is actually consumed.
        if (resp_ready && !resp_fault_q) begin
          if (we_q) st_count_d = st_count_q + 16'd1;
          else      ld_count_d = ld_count_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      size_q       <= 3'd0;
      fault_q      <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_fault_q <= 1'b0;
      ld_count_q   <= 16'd0;
      st_count_q   <= 16'd0;
    end else begin
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      fault_q      <= fault_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
      ld_count_q   <= ld_count_d;
      st_count_q   <= st_count_d;
    end
  end

  // RAM port is gated by rst combinationally so a reset mid-ACCESS blocks the falling-edge write.
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    resp_valid  = (state_q == S_RESP);
    resp_rdata  = resp_rdata_q;
    resp_fault  = resp_fault_q;
    ld_count    = ld_count_q;
    st_count    = st_count_q;
    mem_addr    = 32'd0;
    mem_din     = 32'd0;
    mem_u_b_h_w = 3'd0;
    mem_we      = 1'b0;
    if (state_q == S_ACCESS && !rst) begin
      mem_addr    = addr_q;
      mem_din     = wdata_q;
      mem_u_b_h_w = size_q;
      mem_we      = we_q & ~fault_q;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 128-byte falling-edge RAM model.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_u_b_h_w;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [2:0]  mem_u_b_h_w;
  logic        mem_we;
  logic [31:0] mem_dout;
  logic [15:0] ld_count;
  logic [15:0] st_count;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  logic preload;
  logic [7:0] ram [0:127];

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_u_b_h_w(req_u_b_h_w),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_u_b_h_w(mem_u_b_h_w),
    .mem_we(mem_we), .mem_dout(mem_dout),
    .ld_count(ld_count), .st_count(st_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: little-endian, extension done here, writes on the falling edge.
  always_comb begin
    logic [6:0] a;
    a = mem_addr[6:0];
    mem_dout = 32'd0;
    if (mem_u_b_h_w[1])
      mem_dout = {ram[7'(a + 7'd3)], ram[7'(a + 7'd2)], ram[7'(a + 7'd1)], ram[a]};
    else if (mem_u_b_h_w[0])
      mem_dout = {{16{~mem_u_b_h_w[2] & ram[7'(a + 7'd1)][7]}}, ram[7'(a + 7'd1)], ram[a]};
    else
      mem_dout = {{24{~mem_u_b_h_w[2] & ram[a][7]}}, ram[a]};
  end

  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) ram[i] <= 8'h00;
      ram[64] <= 8'h11;
      ram[65] <= 8'h22;
      ram[66] <= 8'h33;
      ram[67] <= 8'h44;
    end else if (mem_we) begin
      we_cnt <= we_cnt + 1;
      ram[mem_addr[6:0]] <= mem_din[7:0];
      if (mem_u_b_h_w[0] | mem_u_b_h_w[1])
        ram[7'(mem_addr[6:0] + 7'd1)] <= mem_din[15:8];
      if (mem_u_b_h_w[1]) begin
        ram[7'(mem_addr[6:0] + 7'd2)] <= mem_din[23:16];
        ram[7'(mem_addr[6:0] + 7'd3)] <= mem_din[31:24];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] size,
                      output logic [31:0] rd, output logic flt);
    @(posedge clk); #1;
    chk($sformatf("%s_ready", tag), 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_u_b_h_w = size;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_u_b_h_w = 3'd0;
    chk($sformatf("%s_maddr", tag), mem_addr, addr);
    chk($sformatf("%s_vld_acc", tag), 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("%s_vld_resp", tag), 32'(resp_valid), 32'd1);
    chk($sformatf("%s_mwe_resp", tag), 32'(mem_we), 32'd0);
    chk($sformatf("%s_maddr_resp", tag), mem_addr, 32'd0);
    rd = resp_rdata;
    flt = resp_fault;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        flt;
  int          w0;
  logic [15:0] ld_exp, st_exp;

  initial begin
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_u_b_h_w = 3'd0; resp_ready = 1'b0;
    ld_exp = 16'd0; st_exp = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; preload = 1'b0;

    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_ld_count", 32'(ld_count), 32'd0);
    chk("rst_st_count", 32'(st_count), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    xact("st_w10", 1'b1, 32'h10, 32'h12345678, 3'b010, rd, flt);
    st_exp++;
    chk("st_w10_fault", 32'(flt), 32'd0);
    chk("st_w10_rdata", rd, 32'd0);
    xact("ld_b13", 1'b0, 32'h13, 32'd0, 3'b000, rd, flt);
    ld_exp++;
    chk("ld_b13_fault", 32'(flt), 32'd0);
    chk("ld_b13_rdata", rd, 32'h00000012);
    chk("cnt1_st", 32'(st_count), 32'(st_exp));
    chk("cnt1_ld", 32'(ld_count), 32'(ld_exp));

    xact("st_b20", 1'b1, 32'h20, 32'h00000080, 3'b000, rd, flt);
    st_exp++;
    xact("ld_sb20", 1'b0, 32'h20, 32'd0, 3'b000, rd, flt);
    ld_exp++;
    chk("ld_sb20_rdata", rd, 32'hFFFFFF80);
    xact("ld_ub20", 1'b0, 32'h20, 32'd0, 3'b100, rd, flt);
    ld_exp++;
    chk("ld_ub20_rdata", rd, 32'h00000080);

    w0 = we_cnt;
    xact("st_w80", 1'b1, 32'h80, 32'hCAFEF00D, 3'b010, rd, flt);
    chk("st_w80_fault", 32'(flt), 32'd1);
    chk("st_w80_no_we", 32'(we_cnt), 32'(w0));
    chk("st_w80_st_count", 32'(st_count), 32'(st_exp));
    xact("ld_w80", 1'b0, 32'h80, 32'd0, 3'b010, rd, flt);
    chk("ld_w80_fault", 32'(flt), 32'd1);
    chk("ld_w80_rdata", rd, 32'd0);
    xact("ld_hi", 1'b0, 32'h80000010, 32'd0, 3'b010, rd, flt);
    chk("ld_hi_fault", 32'(flt), 32'd1);
    chk("ld_hi_rdata", rd, 32'd0);
    chk("oor_ld_count", 32'(ld_count), 32'(ld_exp));

    xact("ld_h11", 1'b0, 32'h11, 32'd0, 3'b001, rd, flt);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("ld_h11_fault", 32'(flt), 32'd1);
    chk("ld_h11_rdata", rd, 32'd0);
`else
    ld_exp++;
    chk("ld_h11_fault", 32'(flt), 32'd0);
    chk("ld_h11_rdata", rd, 32'h00003456);
`endif
    chk("ld_h11_count", 32'(ld_count), 32'(ld_exp));
    xact("st_h30", 1'b1, 32'h30, 32'h00008001, 3'b001, rd, flt);
    st_exp++;
    xact("ld_h30", 1'b0, 32'h30, 32'd0, 3'b001, rd, flt);
    ld_exp++;
    chk("ld_h30_rdata", rd, 32'hFFFF8001);
    chk("cnt2_st", 32'(st_count), 32'(st_exp));

    // Backpressure in RESP with a competing request held on the input.
    w0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_u_b_h_w = 3'b010;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
    chk("stall_acc_maddr", mem_addr, 32'h10);
    chk("stall_acc_mwe", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_vld%0d", i), 32'(resp_valid), 32'd1);
      chk($sformatf("stall_rdata%0d", i), resp_rdata, 32'h12345678);
      chk($sformatf("stall_rdy%0d", i), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    ld_exp++;
    chk("stall_rel_ready", 32'(req_ready), 32'd1);
    chk("stall_rel_vld", 32'(resp_valid), 32'd0);
    chk("stall_ld_count", 32'(ld_count), 32'(ld_exp));
    @(posedge clk); #1;
    chk("stall_no_accept", 32'(req_ready), 32'd1);
    chk("stall_no_write", 32'(we_cnt), 32'(w0));

    // Reset lands while a store is in ACCESS.
    w0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    req_u_b_h_w = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstacc_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ld_exp = 16'd0; st_exp = 16'd0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rstacc_vld%0d", i), 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("rstacc_ready", 32'(req_ready), 32'd1);
    chk("rstacc_ld_count", 32'(ld_count), 32'd0);
    chk("rstacc_st_count", 32'(st_count), 32'd0);
    chk("rstacc_no_write", 32'(we_cnt), 32'(w0));
    xact("ld_w40", 1'b0, 32'h40, 32'd0, 3'b010, rd, flt);
    ld_exp++;
    chk("ld_w40_rdata", rd, 32'h44332211);
    chk("ld_w40_fault", 32'(flt), 32'd0);
    chk("end_ld_count", 32'(ld_count), 32'(ld_exp));
    chk("end_st_count", 32'(st_count), 32'(st_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL be a one-clock design with synchronous active-high reset; ports are clk and rst.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req_valid  input  1  pipeline presents a load/store request.
REQ-005 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 req_u_b_h_w  input  3  access size: bit0 = halfword, bit1 = word (wins over bit0), bit2 = unsigned load; both clear = byte.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  pipeline consumes the response.
REQ-012 resp_rdata  output  32  load data as returned by the RAM (extension done by the RAM); 0 for stores and faulted accesses.
REQ-013 resp_fault  output  1  access faulted (out-of-range, or misaligned when trapping is enabled).
REQ-014 mem_addr / mem_din / mem_u_b_h_w  output  32/32/3  drive the data RAM address, write data and size/sign ports.
REQ-015 mem_we  output  1  RAM write enable; RAM commits on the falling clk edge.
REQ-016 mem_dout  input  32  combinational RAM read data.
REQ-017 ld_count / st_count  output  16 each  completed non-faulted loads / stores.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-019 IDLE: req_ready = 1; on req_valid, latch req_we, req_addr, req_wdata, req_u_b_h_w and the fault check result, then go to ACCESS.
REQ-020 ACCESS lasts exactly one cycle. mem_addr, mem_din and mem_u_b_h_w drive the latched values. mem_we = latched we AND NOT fault.
REQ-021 At the end of ACCESS, resp_rdata captures mem_dout for non-faulted loads, or 0 otherwise; resp_fault captures the fault flag; the FSM goes to RESP.
REQ-022 RESP: resp_valid = 1, outputs held stable until resp_ready; on resp_ready go to IDLE. A new request is not accepted in the same cycle.
REQ-023 Latency: request accepted at edge N, RAM accessed in cycle N+1, resp_valid from cycle N+2; minimum 3 cycles per access.
REQ-024 Out-of-range fault SHALL be raised when req_addr[31:7] != 0. The RAM is 128 bytes; there is no wrap into the array.
REQ-025 mem_we SHALL be 0 in every state except ACCESS. Outside ACCESS, mem_addr / mem_din / mem_u_b_h_w SHALL be 0.
REQ-026 Counter update rule:
 - ld_count / st_count increment by 1 on the RESP->IDLE transition of a non-faulted load / store.
 - Counters wrap from 0xFFFF to 0.
REQ-027 resp_ready asserted outside RESP SHALL be ignored. req_valid outside IDLE SHALL be ignored; the requester holds the request until req_ready.

Reset
REQ-028 rst SHALL force state IDLE, and zero resp_valid, resp_rdata, resp_fault, ld_count, st_count, all latched request fields and all mem_* outputs.
REQ-029 rst during ACCESS SHALL take priority: mem_we drops before the following falling edge, so no RAM write occurs.
REQ-030 rst during ACCESS or RESP SHALL discard the in-flight response without producing one.

Configuration
REQ-031 Macro MEM_MISALIGN_TRAP_EN.
 - Defined: a halfword with addr[0] = 1, or a word with addr[1:0] != 0, SHALL set fault, suppress mem_we and return rdata 0.
 - Not defined: misaligned accesses proceed to the RAM unchanged, with no fault; only the out-of-range check applies.

Verification
REQ-032 Store word 0x12345678 @0x10, then signed load byte @0x13 -> store resp fault 0, load resp_rdata 0x00000012, st_count 1, ld_count 1.
REQ-033 Store byte 0x80 @0x20, then signed byte load @0x20 -> 0xFFFFFF80; unsigned byte load @0x20 -> 0x00000080.
REQ-034 Store word @0x80 -> resp_fault 1, mem_we never asserted, st_count unchanged; load @0x80 -> rdata 0, fault 1.
REQ-035 Halfword load @0x11: with MEM_MISALIGN_TRAP_EN -> fault 1, rdata 0; without it -> fault 0, rdata = {RAM[0x12], RAM[0x11]} sign-extended.
REQ-036 Hold resp_ready low 5 cycles in RESP with req_valid high -> resp_valid and data stable, req_ready 0; release -> IDLE next cycle.
REQ-037 Assert rst in ACCESS of a store word 0xDEADBEEF @0x40 -> subsequent load @0x40 returns the prior contents, no response emitted, counters 0.
